// File: rtl/sevenseg_mux.sv
// rtl/sevenseg_mux.sv - time-multiplexed scan driver for a multi-digit 7-segment display
module sevenseg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_load,
    input  logic                    in_enable,
    output logic [3:0]              out_digit,
    output logic [NUM_DIGITS-1:0]   out_sel,
    output logic                    out_frame
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DG_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, display_q, display_d;
    logic                    frame_start;
    logic [3:0]              digit_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    frame_d;
    logic                    upper_nz;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            display_q <= '0;
            out_digit <= 4'd0;
            out_sel   <= SEL_IDLE;
            out_frame <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            display_q <= display_d;
            if (in_load) begin
                pending_q <= in_value;
            end
            out_digit <= digit_d;
            out_sel   <= sel_d;
            out_frame <= frame_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        frame_start = 1'b0;
        if (!in_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_start = 1'b1;
                    state_d     = SLOT_START;
                    cnt_d       = '0;
                    idx_d       = '0;
                end
                BLANK: begin
                    if (cnt_q == BL_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end
                end
                SHOW: begin
                    if (cnt_q == DG_LAST) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
        // A load coinciding with the frame start is forwarded so it is not a frame late
        display_d = frame_start ? (in_load ? in_value : pending_q) : display_q;
    end

    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_d) && display_d[4*j +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        sel_d   = '0;
        digit_d = 4'd0;
        if (state_d != IDLE) begin
            digit_d = display_d[{idx_d, 2'b00} +: 4];
        end
        if (state_d == SHOW && !(LZ_BLANK && idx_d != '0 && !upper_nz)) begin
            sel_d = SEL_ONE << idx_d;
        end
        if (SEL_ACTIVE_LOW) begin
            sel_d = ~sel_d;
        end
        frame_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == DG_LAST);
    end

endmodule

// File: tb/tb_sevenseg_mux.sv
// tb/tb_sevenseg_mux.sv - directed self-checking bench for sevenseg_mux
module tb_sevenseg_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic [3:0]  digit, digit2;
    logic [3:0]  sel, sel2;
    logic        frame, frame2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sevenseg_mux #(
        .NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1), .SEL_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)
    ) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_value(value), .in_load(load), .in_enable(enable),
        .out_digit(digit), .out_sel(sel), .out_frame(frame)
    );

    sevenseg_mux #(
        .NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(0), .SEL_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_value(value), .in_load(load), .in_enable(enable),
        .out_digit(digit2), .out_sel(sel2), .out_frame(frame2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 20-clock frame: per slot 1 dark clock then 4 lit; {frame,sel,digit} checked every clock
    task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] supp,
                               input int load_k, input logic [15:0] load_val);
        logic [3:0] e_sel;
        logic [3:0] e_dig;
        logic       e_frm;
        for (int k = 0; k < 20; k++) begin
            step();
            load  = 1'b0;
            e_dig = val[4*(k/5) +: 4];
            e_sel = ((k % 5) == 0 || supp[k/5]) ? 4'b0000 : (4'b0001 << (k/5));
            e_frm = (k == 19);
            chk($sformatf("%s k=%0d", tag, k), {7'd0, e_frm, e_sel, e_dig}, {7'd0, frame, sel, digit});
            if (k == load_k) begin
                load  = 1'b1;
                value = load_val;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        value  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset%0d", i), {7'd0, frame, sel, digit}, 16'h0000);
            chk($sformatf("reset_sel2_%0d", i), {12'd0, sel2}, 16'h000F);
        end

        rst_n  = 1'b1;
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'h1234;
        step();
        chk("idle_after_load", {7'd0, frame, sel, digit}, 16'h0000);
        load   = 1'b0;
        enable = 1'b1;

        check_frame("f1_1234", 16'h1234, 4'b0000, -1, 16'h0000);
        check_frame("f2_1234_midload", 16'h1234, 4'b0000, 7, 16'hABCD);
        check_frame("f3_abcd", 16'hABCD, 4'b0000, 19, 16'h0045);
        check_frame("f4_0045_fwd", 16'h0045, 4'b1100, 19, 16'h0000);
        check_frame("f5_0000", 16'h0000, 4'b1110, 19, 16'h0405);
        check_frame("f6_0405", 16'h0405, 4'b1000, -1, 16'h0000);

        for (int i = 0; i < 12; i++) step();
        chk("lit_d2_before_disable", {12'd0, sel}, 16'h0004);
        enable = 1'b0;
        step();
        chk("disabled_dark", {7'd0, frame, sel, digit}, 16'h0000);
        step();
        chk("disabled_still_dark", {7'd0, frame, sel, digit}, 16'h0000);
        enable = 1'b1;
        check_frame("f7_restart", 16'h0405, 4'b1000, -1, 16'h0000);

        for (int i = 0; i < 12; i++) step();
        chk("lit_d2_before_reset", {12'd0, sel}, 16'h0004);
        rst_n = 1'b0;
        step();
        chk("midscan_reset", {7'd0, frame, sel, digit}, 16'h0000);
        chk("midscan_reset_sel2", {12'd0, sel2}, 16'h000F);
        rst_n = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        check_frame("f8_after_reset", 16'h1234, 4'b0000, -1, 16'h0000);

        enable = 1'b0;
        step();
        step();
        chk("idle_sel2", {12'd0, sel2}, 16'h000F);
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] e_sel;
            logic [3:0] e_dig;
            step();
            e_sel = ~(4'b0001 << (k/4));
            e_dig = 4'(4 - k/4);
            chk($sformatf("al_k=%0d", k), {7'd0, frame2, sel2, digit2},
                {7'd0, (k == 15), e_sel, e_dig});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
